// File: rtl/fetch_align_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_align_pkg : shared types and constants for the fetch realignment queue |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package fetch_align_pkg;

   // Low two bits of a halfword equal to this mark a 32-bit encoding
   localparam logic [1:0] c_rvc_full = 2'b11;

   typedef struct packed {
      logic        err;
      logic [15:0] hw;
   } hw_entry_type;

   typedef struct packed {
      logic        flush;
      logic [31:0] flush_pc;
      logic        valid;
      logic [31:0] pc;
      logic        error;
      logic        out_ready;
   } fetch_align_in_type;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        compressed;
      logic        error;
      logic        illegal;
   } fetch_align_out_type;

   function automatic logic is_full(input logic [15:0] hw);
      return (hw[1:0] == c_rvc_full);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_align_halfword_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | halfword_fifo : ring of halfword entries, up to HPW writes and two reads    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module halfword_fifo
   import fetch_align_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int HPW   = 2,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1),
   localparam int SW   = $clog2(HPW)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              push,
   input  logic [SW-1:0]     push_start,
   input  logic [HPW*16-1:0] push_data,
   input  logic              push_err,
   input  logic              pop,
   input  logic              pop_two,
   output hw_entry_type      h0,
   output hw_entry_type      h1,
   output logic [CW-1:0]     count
);

   hw_entry_type  mem_q [DEPTH];
   hw_entry_type  mem_d [DEPTH];
   logic [PW-1:0] rd_q, rd_d;
   logic [PW-1:0] wr_q, wr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] w_pushed;
   logic [CW-1:0] w_popped;

   always_comb begin
      mem_d    = mem_q;
      w_pushed = '0;
      w_popped = '0;
      if (push) begin
         // Halfwords below the start index precede the useful part of the word
         for (int k = 0; k < HPW; k++) begin
            if (k >= int'(push_start)) begin
               mem_d[wr_q + PW'(k - int'(push_start))] = '{err: push_err, hw: push_data[k*16 +: 16]};
            end
         end
         w_pushed = CW'(HPW - int'(push_start));
      end
      if (pop) begin
         w_popped = pop_two ? CW'(2) : CW'(1);
      end
      count_d = count_q + w_pushed - w_popped;
      rd_d    = rd_q + PW'(w_popped);
      wr_d    = wr_q + PW'(w_pushed);
      if (clear) begin
         count_d = '0;
         rd_d    = '0;
         wr_d    = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_q   <= '{default: '0};
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

   assign h0    = mem_q[rd_q];
   assign h1    = mem_q[rd_q + PW'(1)];
   assign count = count_q;

   a_no_overflow : assert property (@(posedge clock) disable iff (reset)
      (int'(count_q) + int'(w_pushed) - int'(w_popped)) <= DEPTH);

endmodule
`default_nettype wire

// File: rtl/fetch_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_align : realigns fetch words into whole 16/32-bit instructions + PC   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module fetch_align
   import fetch_align_pkg::*;
#(
   parameter int          FETCH_WIDTH = 32,
   parameter int          DEPTH       = 8,
   parameter int          RVC_EN      = 1,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush_in,
   input  logic [31:0]            flush_pc,
   input  logic                   fetch_valid,
   output logic                   fetch_ready,
   input  logic [31:0]            fetch_pc,
   input  logic [FETCH_WIDTH-1:0] fetch_data,
   input  logic                   fetch_error,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_instr,
   output logic [31:0]            out_pc,
   output logic                   out_compressed,
   output logic                   out_error,
   output logic                   out_illegal
);

   localparam int HPW = FETCH_WIDTH / 16;
   localparam int BW  = $clog2(FETCH_WIDTH / 8);
   localparam int SW  = $clog2(HPW);
   localparam int CW  = $clog2(DEPTH + 1);

   fetch_align_in_type  w_in;
   fetch_align_out_type w_out;
   hw_entry_type        w_h0, w_h1;
   logic [CW-1:0]       w_count;
   logic [SW-1:0]       w_start;
   logic                w_push, w_pop, w_pop_two, w_h0_full;
   logic [31:0]         head_pc_q, head_pc_d;
   logic                pend_q, pend_d;
   logic                w_unused;

   assign w_in = '{flush: flush_in, flush_pc: flush_pc, valid: fetch_valid,
                   pc: fetch_pc, error: fetch_error, out_ready: out_ready};

   assign w_start     = w_in.pc[BW-1:1];
   assign fetch_ready = !w_in.flush && ((DEPTH - int'(w_count)) >= HPW);
   assign w_push      = w_in.valid && fetch_ready;
   assign w_h0_full   = is_full(w_h0.hw);
   assign w_unused    = ^{flush_pc[0], fetch_pc};

   halfword_fifo #(
      .DEPTH (DEPTH),
      .HPW   (HPW)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .clear      (w_in.flush),
      .push       (w_push),
      .push_start (w_start),
      .push_data  (fetch_data),
      .push_err   (w_in.error),
      .pop        (w_pop),
      .pop_two    (w_pop_two),
      .h0         (w_h0),
      .h1         (w_h1),
      .count      (w_count)
   );

   // A faulted head halfword goes out alone so the fault is reported at its own PC
   always_comb begin
      w_out     = '0;
      w_pop_two = 1'b0;
      if (w_count != '0) begin
         if (w_h0.err) begin
            w_out.valid      = 1'b1;
            w_out.error      = 1'b1;
            w_out.compressed = 1'b1;
            w_out.pc         = head_pc_q;
         end else if (!w_h0_full) begin
            w_out.valid      = 1'b1;
            w_out.instr      = {16'h0, w_h0.hw};
            w_out.compressed = 1'b1;
            w_out.illegal    = (RVC_EN == 0);
            w_out.pc         = head_pc_q;
         end else if (w_count >= CW'(2)) begin
            w_out.valid = 1'b1;
            w_out.instr = {w_h1.hw, w_h0.hw};
            w_out.error = w_h1.err;
            w_out.pc    = head_pc_q;
            w_pop_two   = 1'b1;
         end
      end
   end

   assign w_pop = w_out.valid && w_in.out_ready && !w_in.flush;

   always_comb begin
      head_pc_d = head_pc_q;
      pend_d    = pend_q;
      if (w_in.flush) begin
         head_pc_d = {w_in.flush_pc[31:1], 1'b0};
         pend_d    = 1'b1;
      end else begin
         if (w_pop) begin
            head_pc_d = head_pc_q + (w_pop_two ? 32'd4 : 32'd2);
         end
         if (w_push) begin
            pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_pc_q <= RESET_PC;
         pend_q    <= 1'b0;
      end else begin
         head_pc_q <= head_pc_d;
         pend_q    <= pend_d;
      end
   end

   assign out_valid      = w_out.valid;
   assign out_instr      = w_out.instr;
   assign out_pc         = w_out.pc;
   assign out_compressed = w_out.compressed;
   assign out_error      = w_out.error;
   assign out_illegal    = w_out.illegal;

   a_redirect_pc : assert property (@(posedge clock) disable iff (reset)
      (w_push && pend_q) |-> (fetch_pc[31:1] == head_pc_q[31:1]));

endmodule
`default_nettype wire

// File: tb/tb_fetch_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_align : directed vectors for a 32-bit and a 64-bit (no RVC) queue  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_fetch_align;

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset;

   logic        a_flush_in, a_fetch_valid, a_fetch_ready, a_fetch_error, a_out_valid, a_out_ready;
   logic [31:0] a_flush_pc, a_fetch_pc, a_fetch_data, a_out_instr, a_out_pc;
   logic        a_out_compressed, a_out_error, a_out_illegal;

   logic        b_flush_in, b_fetch_valid, b_fetch_ready, b_fetch_error, b_out_valid, b_out_ready;
   logic [31:0] b_flush_pc, b_fetch_pc, b_out_instr, b_out_pc;
   logic [63:0] b_fetch_data;
   logic        b_out_compressed, b_out_error, b_out_illegal;

   int n_vec = 0;
   int n_bad = 0;

   fetch_align #(.FETCH_WIDTH(32), .DEPTH(8), .RVC_EN(1), .RESET_PC(32'h0)) u_dut_a (
      .clock(clock), .reset(reset), .flush_in(a_flush_in), .flush_pc(a_flush_pc),
      .fetch_valid(a_fetch_valid), .fetch_ready(a_fetch_ready), .fetch_pc(a_fetch_pc),
      .fetch_data(a_fetch_data), .fetch_error(a_fetch_error), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_instr(a_out_instr), .out_pc(a_out_pc),
      .out_compressed(a_out_compressed), .out_error(a_out_error), .out_illegal(a_out_illegal)
   );

   fetch_align #(.FETCH_WIDTH(64), .DEPTH(8), .RVC_EN(0), .RESET_PC(32'h0)) u_dut_b (
      .clock(clock), .reset(reset), .flush_in(b_flush_in), .flush_pc(b_flush_pc),
      .fetch_valid(b_fetch_valid), .fetch_ready(b_fetch_ready), .fetch_pc(b_fetch_pc),
      .fetch_data(b_fetch_data), .fetch_error(b_fetch_error), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_instr(b_out_instr), .out_pc(b_out_pc),
      .out_compressed(b_out_compressed), .out_error(b_out_error), .out_illegal(b_out_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      a_flush_in = 0; a_flush_pc = 0; a_fetch_valid = 0; a_fetch_pc = 0; a_fetch_data = 0;
      a_fetch_error = 0; a_out_ready = 0;
      b_flush_in = 0; b_flush_pc = 0; b_fetch_valid = 0; b_fetch_pc = 0; b_fetch_data = 0;
      b_fetch_error = 0; b_out_ready = 0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      chk("rst_a_valid", a_out_valid, 0);
      chk("rst_a_instr", a_out_instr, 0);
      chk("rst_a_pc", a_out_pc, 0);
      chk("rst_a_ready", a_fetch_ready, 1);
      chk("rst_b_valid", b_out_valid, 0);
      chk("rst_b_ready", b_fetch_ready, 1);

      // aligned 32-bit stream
      a_fetch_valid = 1; a_fetch_pc = 32'h0; a_fetch_data = 32'h00000013; a_out_ready = 1;
      #1 chk("al_first_cycle", a_out_valid, 0);
      step(); a_fetch_pc = 32'h4;
      #1 chk("al_v0", a_out_valid, 1); chk("al_pc0", a_out_pc, 32'h0);
      chk("al_i0", a_out_instr, 32'h13); chk("al_c0", a_out_compressed, 0);
      step(); a_fetch_pc = 32'h8;
      #1 chk("al_v1", a_out_valid, 1); chk("al_pc1", a_out_pc, 32'h4);
      step(); a_fetch_valid = 0;
      #1 chk("al_pc2", a_out_pc, 32'h8);
      step();
      #1 chk("al_idle_v", a_out_valid, 0); chk("al_idle_pc", a_out_pc, 0);

      // straddling 32-bit instruction
      a_flush_in = 1; a_flush_pc = 32'h0;
      #1 chk("fl_ready", a_fetch_ready, 0);
      step(); a_flush_in = 0; a_fetch_valid = 1; a_fetch_pc = 32'h0; a_fetch_data = 32'h00134501;
      #1 chk("st_empty", a_out_valid, 0);
      step(); a_fetch_valid = 0;
      #1 chk("st_v1", a_out_valid, 1); chk("st_i1", a_out_instr, 32'h00004501);
      chk("st_p1", a_out_pc, 32'h0); chk("st_c1", a_out_compressed, 1);
      step();
      #1 chk("st_hold", a_out_valid, 0);
      step(); a_fetch_valid = 1; a_fetch_pc = 32'h4; a_fetch_data = 32'h00000513;
      #1 chk("st_hold2", a_out_valid, 0);
      step(); a_fetch_valid = 0;
      #1 chk("st_v2", a_out_valid, 1); chk("st_i2", a_out_instr, 32'h05130013);
      chk("st_p2", a_out_pc, 32'h2); chk("st_c2", a_out_compressed, 0);
      step();
      #1 chk("st_v3", a_out_valid, 1); chk("st_p3", a_out_pc, 32'h6); chk("st_i3", a_out_instr, 0);
      step();
      #1 chk("st_drained", a_out_valid, 0);

      // fetch faults
      a_flush_in = 1; a_flush_pc = 32'h22;
      step(); a_flush_in = 0; a_fetch_valid = 1; a_fetch_pc = 32'h22; a_fetch_data = 32'h0013BEEF;
      step(); a_fetch_pc = 32'h24; a_fetch_data = 32'h00030000; a_fetch_error = 1;
      #1 chk("ft_hold", a_out_valid, 0);
      step(); a_fetch_valid = 0; a_fetch_error = 0;
      #1 chk("ft_v", a_out_valid, 1); chk("ft_err", a_out_error, 1);
      chk("ft_pc", a_out_pc, 32'h22); chk("ft_i", a_out_instr, 32'h13);
      step();
      #1 chk("ft_v2", a_out_valid, 1); chk("ft_err2", a_out_error, 1);
      chk("ft_i2", a_out_instr, 0); chk("ft_pc2", a_out_pc, 32'h26);
      step();
      #1 chk("ft_done", a_out_valid, 0);

      // flush together with fetch and pop, then odd-halfword redirect
      a_fetch_valid = 1; a_fetch_pc = 32'h28; a_fetch_data = 32'h00000013; a_out_ready = 0;
      step(); a_fetch_valid = 0;
      #1 chk("fs_pre_v", a_out_valid, 1); chk("fs_pre_pc", a_out_pc, 32'h28);
      a_flush_in = 1; a_flush_pc = 32'h107; a_fetch_valid = 1; a_fetch_pc = 32'h2C; a_out_ready = 1;
      #1 chk("fs_ready", a_fetch_ready, 0);
      step(); a_flush_in = 0; a_fetch_valid = 0; a_out_ready = 0;
      #1 chk("fs_valid", a_out_valid, 0); chk("fs_pc", a_out_pc, 0);
      a_fetch_valid = 1; a_fetch_pc = 32'h106; a_fetch_data = 32'h4501BEEF; a_out_ready = 1;
      #1 chk("fs_ready2", a_fetch_ready, 1);
      step(); a_fetch_valid = 0;
      #1 chk("rd_v", a_out_valid, 1); chk("rd_pc", a_out_pc, 32'h106);
      chk("rd_i", a_out_instr, 32'h4501); chk("rd_c", a_out_compressed, 1);
      chk("rd_ill", a_out_illegal, 0);
      step();
      #1 chk("rd_done", a_out_valid, 0);

      // 64-bit backpressure
      b_flush_in = 1; b_flush_pc = 32'h4;
      step(); b_flush_in = 0; b_fetch_valid = 1; b_fetch_pc = 32'h4;
      b_fetch_data = 64'h00000013_DEADBEEF;
      #1 chk("bp_r0", b_fetch_ready, 1);
      step(); b_fetch_pc = 32'h8; b_fetch_data = 64'h00000013_00000013;
      #1 chk("bp_r1", b_fetch_ready, 1);
      step(); b_fetch_valid = 0;
      #1 chk("bp_full", b_fetch_ready, 0); chk("bp_v", b_out_valid, 1);
      chk("bp_pc", b_out_pc, 32'h4); chk("bp_i", b_out_instr, 32'h13);
      b_out_ready = 1;
      #1 chk("bp_samecyc", b_fetch_ready, 0);
      step(); b_out_ready = 0;
      #1 chk("bp_back", b_fetch_ready, 1); chk("bp_pc2", b_out_pc, 32'h8);

      // compressed encodings illegal when RVC is disabled
      b_flush_in = 1; b_flush_pc = 32'h100;
      step(); b_flush_in = 0; b_fetch_valid = 1; b_fetch_pc = 32'h100;
      b_fetch_data = 64'h4501_4501_4501_4501; b_out_ready = 1;
      step(); b_fetch_valid = 0;
      #1 chk("il_v", b_out_valid, 1); chk("il_i", b_out_instr, 32'h4501);
      chk("il_c", b_out_compressed, 1); chk("il_ill", b_out_illegal, 1);
      chk("il_pc", b_out_pc, 32'h100);
      step();
      #1 chk("il_pc2", b_out_pc, 32'h102); chk("il_ill2", b_out_illegal, 1);

      // asynchronous reset mid-stream
      b_out_ready = 0;
      reset = 1'b1;
      #1 chk("ar_b_valid", b_out_valid, 0); chk("ar_b_pc", b_out_pc, 0);
      chk("ar_b_ready", b_fetch_ready, 1);
      reset = 1'b0;
      step();
      #1 chk("ar_b_after", b_out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
